// File: rtl/udma_i2c_reg_if_mc_if.sv
// cfg bus between the uDMA interconnect and the multi-channel I2C register file.
interface udma_i2c_reg_if_mc_if;
    logic [31:0] cfg_data_i;
    logic [7:0]  cfg_addr_i;
    logic        cfg_valid_i;
    logic        cfg_rwn_i;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;

    modport master (
        output cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        input  cfg_data_o, cfg_ready_o
    );

    modport slave (
        input  cfg_data_i, cfg_addr_i, cfg_valid_i, cfg_rwn_i,
        output cfg_data_o, cfg_ready_o
    );
endinterface

// File: rtl/udma_i2c_reg_if_mc.sv
// Multi-channel uDMA I2C register file: RX/TX channel setup, soft reset, sticky status.
// Define UDMA_I2C_IRQ_EN to build the per-channel interrupt enables and irq_o logic.
module udma_i2c_reg_if_mc #(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned RST_CYCLES     = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    udma_i2c_reg_if_mc_if.slave            cfg,

    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,

    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_size_o,
    output logic [N_CH-1:0]                cfg_tx_continuous_o,
    output logic [N_CH-1:0]                cfg_tx_en_o,
    output logic [N_CH-1:0]                cfg_tx_clr_o,
    input  logic [N_CH-1:0]                cfg_tx_en_i,
    input  logic [N_CH-1:0]                cfg_tx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_tx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_tx_bytes_left_i,

    output logic [N_CH-1:0]                cfg_do_rst_o,
    input  logic [N_CH-1:0]                status_busy_i,
    input  logic [N_CH-1:0]                status_al_i,
    input  logic [N_CH-1:0]                status_nack_i,
    output logic [N_CH-1:0]                irq_o
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);

    logic [L2_AWIDTH_NOAL-1:0] r_rx_saddr [N_CH];
    logic [L2_AWIDTH_NOAL-1:0] r_tx_saddr [N_CH];
    logic [TRANS_SIZE-1:0]     r_rx_size  [N_CH];
    logic [TRANS_SIZE-1:0]     r_tx_size  [N_CH];
    logic [CNT_W-1:0]          r_rst_cnt  [N_CH];
    logic [2:0]                r_sticky   [N_CH];
    logic [N_CH-1:0]           r_rx_cont, r_rx_en, r_rx_clr;
    logic [N_CH-1:0]           r_tx_cont, r_tx_en, r_tx_clr;

    logic [L2_AWIDTH_NOAL-1:0] w_rx_curr [N_CH];
    logic [L2_AWIDTH_NOAL-1:0] w_tx_curr [N_CH];
    logic [TRANS_SIZE-1:0]     w_rx_left [N_CH];
    logic [TRANS_SIZE-1:0]     w_tx_left [N_CH];
    logic [2:0]                w_ien     [N_CH];

    logic [4:0]      w_ch;
    logic [2:0]      w_reg;
    logic            w_ch_ok;
    logic [CH_W-1:0] w_chi;
    logic [N_CH-1:0] w_wr_sel;
    logic [N_CH-1:0] w_st_clr;
    logic [31:0]     w_rdata;

    assign w_ch    = cfg.cfg_addr_i[7:3];
    assign w_reg   = cfg.cfg_addr_i[2:0];
    assign w_ch_ok = ({1'b0, w_ch} < 6'(N_CH));
    // Out-of-range channels are clamped to 0 so array indexing stays in bounds; w_ch_ok gates any effect.
    assign w_chi   = w_ch_ok ? w_ch[CH_W-1:0] : '0;

    assign cfg.cfg_ready_o = 1'b1;

    always_comb begin
        w_wr_sel = '0;
        w_st_clr = '0;
        if (cfg.cfg_valid_i && w_ch_ok) begin
            if (!cfg.cfg_rwn_i)
                w_wr_sel[w_chi] = 1'b1;
            else if (w_reg == 3'd7)
                w_st_clr[w_chi] = 1'b1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_rx_curr[c] = cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        assign w_tx_curr[c] = cfg_tx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        assign w_rx_left[c] = cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE];
        assign w_tx_left[c] = cfg_tx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE];

        assign cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = r_rx_saddr[c];
        assign cfg_tx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL] = r_tx_saddr[c];
        assign cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]              = r_rx_size[c];
        assign cfg_tx_size_o[c*TRANS_SIZE +: TRANS_SIZE]              = r_tx_size[c];
        assign cfg_do_rst_o[c] = (r_rst_cnt[c] != '0);
    end

    assign cfg_rx_continuous_o = r_rx_cont;
    assign cfg_rx_en_o         = r_rx_en;
    assign cfg_rx_clr_o        = r_rx_clr;
    assign cfg_tx_continuous_o = r_tx_cont;
    assign cfg_tx_en_o         = r_tx_en;
    assign cfg_tx_clr_o        = r_tx_clr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_cont <= '0;
            r_rx_en   <= '0;
            r_rx_clr  <= '0;
            r_tx_cont <= '0;
            r_tx_en   <= '0;
            r_tx_clr  <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_rx_saddr[c] <= '0;
                r_tx_saddr[c] <= '0;
                r_rx_size[c]  <= '0;
                r_tx_size[c]  <= '0;
                r_rst_cnt[c]  <= '0;
                r_sticky[c]   <= '0;
            end
        end else begin
            r_rx_en  <= '0;
            r_rx_clr <= '0;
            r_tx_en  <= '0;
            r_tx_clr <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                // New events are OR-ed after the read-clear so a coincident strobe survives.
                r_sticky[c] <= (w_st_clr[c] ? 3'b000 : r_sticky[c])
                             | {status_nack_i[c], status_al_i[c], status_busy_i[c]};
                if (r_rst_cnt[c] != '0)
                    r_rst_cnt[c] <= r_rst_cnt[c] - 1'b1;
                if (w_wr_sel[c]) begin
                    case (w_reg)
                        3'd0: r_rx_saddr[c] <= cfg.cfg_data_i[L2_AWIDTH_NOAL-1:0];
                        3'd1: r_rx_size[c]  <= cfg.cfg_data_i[TRANS_SIZE-1:0];
                        3'd2: begin
                            r_rx_clr[c]  <= cfg.cfg_data_i[5];
                            r_rx_en[c]   <= cfg.cfg_data_i[4];
                            r_rx_cont[c] <= cfg.cfg_data_i[0];
                        end
                        3'd3: r_tx_saddr[c] <= cfg.cfg_data_i[L2_AWIDTH_NOAL-1:0];
                        3'd4: r_tx_size[c]  <= cfg.cfg_data_i[TRANS_SIZE-1:0];
                        3'd5: begin
                            r_tx_clr[c]  <= cfg.cfg_data_i[5];
                            r_tx_en[c]   <= cfg.cfg_data_i[4];
                            r_tx_cont[c] <= cfg.cfg_data_i[0];
                        end
                        3'd6: begin
                            if (cfg.cfg_data_i[0])
                                r_rst_cnt[c] <= CNT_W'(RST_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef UDMA_I2C_IRQ_EN
    logic [2:0]      r_ien [N_CH];
    logic [N_CH-1:0] r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= '0;
            for (int unsigned c = 0; c < N_CH; c++)
                r_ien[c] <= '0;
        end else begin
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_irq[c] <= |(r_sticky[c] & r_ien[c]);
                if (w_wr_sel[c] && (w_reg == 3'd6))
                    r_ien[c] <= cfg.cfg_data_i[10:8];
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ien
        assign w_ien[c] = r_ien[c];
    end
    assign irq_o = r_irq;
`else
    for (genvar c = 0; c < N_CH; c++) begin : g_ien
        assign w_ien[c] = 3'b000;
    end
    assign irq_o = '0;
`endif

    always_comb begin
        w_rdata = '0;
        if (cfg.cfg_valid_i && cfg.cfg_rwn_i && w_ch_ok) begin
            case (w_reg)
                3'd0: w_rdata = 32'(w_rx_curr[w_chi]);
                3'd1: w_rdata = 32'(w_rx_left[w_chi]);
                3'd2: w_rdata = {26'h0, cfg_rx_pending_i[w_chi], cfg_rx_en_i[w_chi], 3'h0, r_rx_cont[w_chi]};
                3'd3: w_rdata = 32'(w_tx_curr[w_chi]);
                3'd4: w_rdata = 32'(w_tx_left[w_chi]);
                3'd5: w_rdata = {26'h0, cfg_tx_pending_i[w_chi], cfg_tx_en_i[w_chi], 3'h0, r_tx_cont[w_chi]};
                3'd6: w_rdata = {21'h0, w_ien[w_chi], 7'h0, cfg_do_rst_o[w_chi]};
                default: w_rdata = {29'h0, r_sticky[w_chi]};
            endcase
        end
    end

    assign cfg.cfg_data_o = w_rdata;

endmodule

// File: tb/tb_udma_i2c_reg_if_mc.sv
// Directed bench for udma_i2c_reg_if_mc with N_CH=2, L2_AWIDTH_NOAL=12, TRANS_SIZE=16, RST_CYCLES=4.
module tb_udma_i2c_reg_if_mc;
    localparam int unsigned N_CH = 2;
    localparam int unsigned AW   = 12;
    localparam int unsigned TS   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udma_i2c_reg_if_mc_if cfg_bus ();

    logic [N_CH*AW-1:0] rx_saddr_o, tx_saddr_o, rx_curr_i, tx_curr_i;
    logic [N_CH*TS-1:0] rx_size_o, tx_size_o, rx_left_i, tx_left_i;
    logic [N_CH-1:0]    rx_cont_o, rx_en_o, rx_clr_o, tx_cont_o, tx_en_o, tx_clr_o;
    logic [N_CH-1:0]    rx_en_i, rx_pend_i, tx_en_i, tx_pend_i;
    logic [N_CH-1:0]    do_rst_o, busy_i, al_i, nack_i, irq_o;

    udma_i2c_reg_if_mc #(
        .N_CH(N_CH), .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .RST_CYCLES(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .cfg(cfg_bus),
        .cfg_rx_startaddr_o(rx_saddr_o), .cfg_rx_size_o(rx_size_o),
        .cfg_rx_continuous_o(rx_cont_o), .cfg_rx_en_o(rx_en_o), .cfg_rx_clr_o(rx_clr_o),
        .cfg_rx_en_i(rx_en_i), .cfg_rx_pending_i(rx_pend_i),
        .cfg_rx_curr_addr_i(rx_curr_i), .cfg_rx_bytes_left_i(rx_left_i),
        .cfg_tx_startaddr_o(tx_saddr_o), .cfg_tx_size_o(tx_size_o),
        .cfg_tx_continuous_o(tx_cont_o), .cfg_tx_en_o(tx_en_o), .cfg_tx_clr_o(tx_clr_o),
        .cfg_tx_en_i(tx_en_i), .cfg_tx_pending_i(tx_pend_i),
        .cfg_tx_curr_addr_i(tx_curr_i), .cfg_tx_bytes_left_i(tx_left_i),
        .cfg_do_rst_o(do_rst_o), .status_busy_i(busy_i), .status_al_i(al_i),
        .status_nack_i(nack_i), .irq_o(irq_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        cfg_bus.cfg_addr_i  = 8'((ch << 3) | rg);
        cfg_bus.cfg_data_i  = d;
        cfg_bus.cfg_rwn_i   = 1'b0;
        cfg_bus.cfg_valid_i = 1'b1;
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, input logic [31:0] exp, input string tag);
        cfg_bus.cfg_addr_i  = 8'((ch << 3) | rg);
        cfg_bus.cfg_rwn_i   = 1'b1;
        cfg_bus.cfg_valid_i = 1'b1;
        #1;
        check(tag, cfg_bus.cfg_data_o, exp);
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
    endtask

    logic [31:0] exp0 [8];
    logic [31:0] exp1 [8];
    int n;

    initial begin
        cfg_bus.cfg_data_i = '0; cfg_bus.cfg_addr_i = '0;
        cfg_bus.cfg_valid_i = 1'b0; cfg_bus.cfg_rwn_i = 1'b0;
        rx_curr_i = '0; tx_curr_i = '0; rx_left_i = '0; tx_left_i = '0;
        rx_en_i = '0; rx_pend_i = '0; tx_en_i = '0; tx_pend_i = '0;
        busy_i = '0; al_i = '0; nack_i = '0;
        rx_curr_i[11:0] = 12'h123;
        rx_left_i[15:0] = 16'h0055;
        rx_pend_i[1] = 1'b1;
        tx_en_i[1]   = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        check("rst_rx_saddr", 32'(rx_saddr_o), 32'h0);
        check("rst_do_rst", 32'(do_rst_o), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("ready", 32'(cfg_bus.cfg_ready_o), 32'h1);

        exp0 = '{32'h123, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        exp1 = '{32'h0, 32'h0, 32'h20, 32'h0, 32'h0, 32'h10, 32'h0, 32'h0};
        for (int r = 0; r < 8; r++) rd(0, r, exp0[r], $sformatf("rst_ch0_r%0d", r));
        for (int r = 0; r < 8; r++) rd(1, r, exp1[r], $sformatf("rst_ch1_r%0d", r));
        rd(2, 0, 32'h0, "bad_ch_rd0");
        rd(2, 2, 32'h0, "bad_ch_rd2");

        // RX_CFG pulses on channel 1 only
        wr(1, 2, 32'h31);
        check("rxclr_pulse", 32'(rx_clr_o), 32'h2);
        check("rxen_pulse", 32'(rx_en_o), 32'h2);
        check("rxcont_set", 32'(rx_cont_o), 32'h2);
        tick();
        check("rxclr_low", 32'(rx_clr_o), 32'h0);
        check("rxen_low", 32'(rx_en_o), 32'h0);
        check("rxcont_hold", 32'(rx_cont_o), 32'h2);
        rd(1, 2, 32'h21, "rxcfg_rd_ch1");

        // back-to-back TX enable pulses on channel 0
        cfg_bus.cfg_addr_i = 8'h05; cfg_bus.cfg_data_i = 32'h10;
        cfg_bus.cfg_rwn_i = 1'b0; cfg_bus.cfg_valid_i = 1'b1;
        tick();
        check("txen_b2b_1", 32'(tx_en_o), 32'h1);
        tick();
        cfg_bus.cfg_valid_i = 1'b0;
        check("txen_b2b_2", 32'(tx_en_o), 32'h1);
        tick();
        check("txen_b2b_low", 32'(tx_en_o), 32'h0);

        // start address truncation, size, ignored channel write
        wr(1, 0, 32'hFFFF_FABC);
        check("rx_saddr_ch1", 32'(rx_saddr_o[23:12]), 32'hABC);
        check("rx_saddr_ch0", 32'(rx_saddr_o[11:0]), 32'h0);
        wr(0, 4, 32'h0001_2345);
        check("tx_size_ch0", 32'(tx_size_o[15:0]), 32'h2345);
        wr(2, 0, 32'h111);
        check("bad_ch_wr", 32'(rx_saddr_o), 32'hABC000);

        // soft reset length
        wr(0, 6, 32'h1);
        n = 0;
        while (do_rst_o[0] && n < 20) begin n++; tick(); end
        check("do_rst_len", 32'(n), 32'd4);

        // retrigger during second cycle extends to 6
        wr(0, 6, 32'h1);
        n = 0;
        if (do_rst_o[0]) n++;
        tick();
        if (do_rst_o[0]) n++;
        wr(0, 6, 32'h1);
        while (do_rst_o[0] && n < 20) begin n++; tick(); end
        check("do_rst_ext", 32'(n), 32'd6);

        // bit0=0 write does not disturb a running pulse
        wr(1, 6, 32'h1);
        n = 0;
        if (do_rst_o[1]) n++;
        wr(1, 6, 32'h0);
        while (do_rst_o[1] && n < 20) begin n++; tick(); end
        check("do_rst_noext", 32'(n), 32'd4);

        // SETUP read reflects active pulse
        wr(0, 6, 32'h1);
        rd(0, 6, 32'h1, "setup_active");

        // reset mid-pulse
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_pulse", 32'(do_rst_o), 32'h0);
        check("rst_cont", 32'(rx_cont_o), 32'h0);
        check("rst_saddr", 32'(rx_saddr_o), 32'h0);

        // sticky status
        al_i[0] = 1'b1; tick(); al_i[0] = 1'b0;
        rd(0, 7, 32'h2, "st_al");
        rd(0, 7, 32'h0, "st_al_clr");
        al_i[0] = 1'b1; tick(); al_i[0] = 1'b0;
        al_i[0] = 1'b1;
        rd(0, 7, 32'h2, "st_coinc");
        al_i[0] = 1'b0;
        rd(0, 7, 32'h2, "st_coinc_kept");
        rd(0, 7, 32'h0, "st_coinc_clr");
        busy_i[1] = 1'b1; nack_i[1] = 1'b1; tick(); busy_i[1] = 1'b0; nack_i[1] = 1'b0;
        rd(1, 7, 32'h5, "st_busy_nack");
        rd(0, 7, 32'h0, "st_ch0_quiet");

        // interrupts
        wr(1, 6, 32'h400);
`ifdef UDMA_I2C_IRQ_EN
        rd(1, 6, 32'h400, "setup_ien");
        nack_i[1] = 1'b1; tick(); nack_i[1] = 1'b0;
        tick();
        check("irq_set", 32'(irq_o), 32'h2);
        rd(1, 7, 32'h4, "irq_status");
        tick();
        check("irq_clr", 32'(irq_o), 32'h0);
`else
        rd(1, 6, 32'h0, "setup_ien");
        nack_i[1] = 1'b1; tick(); nack_i[1] = 1'b0;
        tick();
        check("irq_off", 32'(irq_o), 32'h0);
        rd(1, 7, 32'h4, "irq_status");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
